// File: rtl/rv32_pkg.sv
// Shared RV32 fetch-path constants, the fetch buffer entry type and a PC alignment helper.
package rv32_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instruction;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO holding fetched {pc, instruction} pairs; head is entry 0.
module fetch_buffer
    import rv32_pkg::*;
(
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o
);

    logic [1:0]   count_q, count_d;
    fetch_entry_t head_q, head_d;
    fetch_entry_t tail_q, tail_d;
    logic         pop, push;

    always_comb begin
        pop     = pop_i && (count_q != 2'd0);
        push    = push_i && ((count_q != 2'd2) || pop);
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        // Flush beats a same-cycle push or pop.
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = push_entry_i;
                    end else begin
                        tail_d = push_entry_i;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_d = push_entry_i;
                    end else begin
                        head_d = tail_q;
                        tail_d = push_entry_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = head_q;

endmodule

// File: rtl/fetch_rv32.sv
// RV32 fetch stage: PC, single-outstanding memory requests, 2-entry buffer to decode.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect raises sticky fetch_fault and halts fetch.
module fetch_rv32
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter int unsigned BUFFER_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    output logic [31:0] memory_read_address,
    output logic        read_enable,
    input  logic        memory_read_valid,
    input  logic [31:0] memory_read_value,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instruction_valid,
    input  logic        decode_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_instruction,
    output logic        fetch_fault
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_RESP = 2'd1;
    localparam logic [1:0] HALT      = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         discard_q, discard_d;
    logic         fault_q, fault_d;

    logic         outstanding, issue, push, misaligned;
    logic [1:0]   fifo_count;
    fetch_entry_t fifo_head, push_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned  = |redirect_pc[1:0];
    assign fetch_fault = fault_q;
`else
    assign misaligned  = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    assign outstanding = (state_q == WAIT_RESP);
    // Gated by reset_n so no request strobe is seen while reset is held.
    assign issue = reset_n && enable && (state_q == IDLE) && (32'(fifo_count) < BUFFER_DEPTH)
                   && !redirect_valid;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;
        fault_d    = fault_q;
        push       = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
            fault_d    = misaligned;
            if (outstanding && !memory_read_valid) begin
                discard_d = 1'b1;
            end else begin
                discard_d = 1'b0;
                state_d   = misaligned ? HALT : IDLE;
            end
        end else if (outstanding && memory_read_valid) begin
            push      = !discard_q;
            discard_d = 1'b0;
            state_d   = fault_q ? HALT : IDLE;
        end else if (issue) begin
            state_d    = WAIT_RESP;
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            discard_q  <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            discard_q  <= discard_d;
            fault_q    <= fault_d;
        end
    end

    assign push_entry.pc          = req_pc_q;
    assign push_entry.instruction = memory_read_value;

    fetch_buffer u_fetch_buffer (
        .clock        (clock),
        .reset_n      (reset_n),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (instruction_valid && decode_ready),
        .flush_i      (redirect_valid),
        .count_o      (fifo_count),
        .head_o       (fifo_head)
    );

    assign memory_read_address = fetch_pc_q;
    assign read_enable         = issue;
    assign instruction_valid   = (fifo_count != 2'd0);
    assign pc                  = fifo_head.pc;
    assign pc_instruction      = fifo_head.instruction;

endmodule
